// File: rtl/seq_control_fsm.sv
// Multi-cycle MiniMicro instruction sequencer: fetch, decode, then step the
// ALU / register file / data memory through EXEC, MEM and WB one instruction at a time.
module seq_control_fsm #(
    parameter int word_size   = 32,
    parameter int opcode_size = 5,
    parameter int addr_chunk  = 9,
    parameter int pc_size     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [pc_size-1:0]     imem_addr,
    input  logic                   imem_ready,
    input  logic [word_size-1:0]   imem_rdata,
    output logic [addr_chunk-1:0]  rf_raddr1,
    output logic [addr_chunk-1:0]  rf_raddr2,
    input  logic [word_size-1:0]   rf_rdata1,
    output logic [addr_chunk-1:0]  rf_waddr,
    output logic                   rf_we,
    output logic [1:0]             wb_sel,
    output logic [word_size-1:0]   imm,
    output logic [opcode_size-1:0] alu_op,
    input  logic [3:0]             alu_flags,
    output logic [3:0]             flags,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [addr_chunk-1:0]  dmem_addr,
    output logic [word_size-1:0]   dmem_wdata,
    input  logic                   dmem_ready,
    output logic                   halted,
    output logic                   illegal
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [opcode_size-1:0] OP_NOP    = 5'd0;
    localparam logic [opcode_size-1:0] OP_ALU_LO = 5'd1;
    localparam logic [opcode_size-1:0] OP_ALU_HI = 5'd17;
    localparam logic [opcode_size-1:0] OP_CMP    = 5'd18;
    localparam logic [opcode_size-1:0] OP_LOAD   = 5'd19;
    localparam logic [opcode_size-1:0] OP_STORE  = 5'd20;
    localparam logic [opcode_size-1:0] OP_MOV    = 5'd21;
    localparam logic [opcode_size-1:0] OP_J      = 5'd22;
    localparam logic [opcode_size-1:0] OP_BEQ    = 5'd23;
    localparam logic [opcode_size-1:0] OP_HLT    = 5'd24;

    state_t                   state, state_next;
    logic                     run;
    logic [pc_size-1:0]       pc, pc_next;
    logic [word_size-1:0]     instr, instr_next;
    logic [3:0]               flags_next;

    logic [opcode_size-1:0]   opcode;
    logic [addr_chunk-1:0]    dest, src1, src2;

    assign opcode    = instr[31:27];
    assign dest      = instr[26:18];
    assign src1      = instr[17:9];
    assign src2      = instr[8:0];
    assign imm       = {{(word_size-18){1'b0}}, instr[17:0]};
    assign imem_addr = pc;

    // run holds off the first fetch request until one edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
            run   <= 1'b0;
            pc    <= '0;
            instr <= '0;
            flags <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state <= state_next;
            run   <= 1'b1;
            pc    <= pc_next;
            instr <= instr_next;
            flags <= flags_next;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path infers a latch.
        state_next = state;
        pc_next    = pc;
        instr_next = instr;
        flags_next = flags;
        imem_req   = 1'b0;
        rf_raddr1  = '0;
        rf_raddr2  = '0;
        rf_waddr   = '0;
        rf_we      = 1'b0;
        wb_sel     = 2'd0;
        alu_op     = '0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        halted     = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                if (run) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        instr_next = imem_rdata;
                        pc_next    = pc + 1'b1;
                        state_next = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                rf_raddr1 = src1;
                rf_raddr2 = src2;
                if (opcode == OP_NOP) begin
                    state_next = S_FETCH;
                end else if (opcode > OP_HLT) begin
                    illegal    = 1'b1;
                    state_next = S_FETCH;
                end else if (opcode == OP_J) begin
                    pc_next    = instr[pc_size-1:0];
                    state_next = S_FETCH;
                end else if (opcode == OP_BEQ) begin
                    if (flags[2]) pc_next = instr[pc_size-1:0];
                    state_next = S_FETCH;
                end else if (opcode == OP_HLT) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                rf_raddr1 = src1;
                rf_raddr2 = src2;
                rf_waddr  = dest;
                if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) begin
                    alu_op     = opcode;
                    flags_next = alu_flags;
                    rf_we      = 1'b1;
                    state_next = S_FETCH;
                end else if (opcode == OP_CMP) begin
                    alu_op     = OP_CMP;
                    flags_next = alu_flags;
                    state_next = S_FETCH;
                end else if (opcode == OP_MOV) begin
                    rf_we      = 1'b1;
                    wb_sel     = 2'd2;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_MEM;
                end
            end
            S_MEM: begin
                rf_raddr1  = src1;
                rf_raddr2  = src2;
                dmem_req   = 1'b1;
                dmem_we    = (opcode == OP_STORE);
                dmem_addr  = (opcode == OP_STORE) ? dest : src1;
                dmem_wdata = rf_rdata1;
                if (dmem_ready) state_next = (opcode == OP_LOAD) ? S_WB : S_FETCH;
            end
            S_WB: begin
                rf_we      = 1'b1;
                wb_sel     = 2'd1;
                rf_waddr   = dest;
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_seq_control_fsm.sv
// Directed self-checking bench for seq_control_fsm: hand-computed expectations
// checked with immediate assertions at fixed points in the instruction stream.
module tb_seq_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [8:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0] rf_rdata1;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [3:0]  alu_flags, flags;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [8:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        halted, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    seq_control_fsm dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_waddr(rf_waddr), .rf_we(rf_we), .wb_sel(wb_sel), .imm(imm),
        .alu_op(alu_op), .alu_flags(alu_flags), .flags(flags),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and land 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [8:0] d,
                                       input logic [8:0] s1, input logic [8:0] s2);
        return {op, d, s1, s2};
    endfunction

    // Entered in FETCH with the request visible; returns in DECODE.
    task automatic fetch(input logic [31:0] ins, input logic [7:0] addr, input int waits);
        check("fetch_addr", {24'd0, imem_addr}, {24'd0, addr});
        for (int i = 0; i < waits; i++) begin
            check("fetch_wait_req", {31'd0, imem_req}, 32'd1);
            step();
        end
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        imem_rdata = ins;
        step();
        imem_ready = 1'b0;
        imem_rdata = '0;
    endtask

    initial begin
        rst = 1'b0; imem_ready = 0; imem_rdata = '0; rf_rdata1 = '0;
        alu_flags = '0; dmem_ready = 0;

        step(); step();
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b1;
        step();

        // MOV r3,#0x12345 at PC 0: write-back on cycle 3
        fetch({5'd21, 9'd3, 18'h12345}, 8'h00, 0);
        check("mov_dec_rf_we", {31'd0, rf_we}, 32'd0);
        check("mov_dec_pc", {24'd0, imem_addr}, 32'h1);
        step();
        check("mov_rf_we", {31'd0, rf_we}, 32'd1);
        check("mov_wb_sel", {30'd0, wb_sel}, 32'd2);
        check("mov_waddr", {23'd0, rf_waddr}, 32'd3);
        check("mov_imm", imm, 32'h0001_2345);
        check("mov_alu_op", {27'd0, alu_op}, 32'd0);
        step();

        // ADDS r1,r2,r4 at PC 1
        fetch(mk(5'd6, 9'd1, 9'd2, 9'd4), 8'h01, 0);
        check("adds_raddr1", {23'd0, rf_raddr1}, 32'd2);
        check("adds_raddr2", {23'd0, rf_raddr2}, 32'd4);
        check("adds_dec_alu_op", {27'd0, alu_op}, 32'd0);
        alu_flags = 4'b0100;
        step();
        check("adds_alu_op", {27'd0, alu_op}, 32'd6);
        check("adds_rf_we", {31'd0, rf_we}, 32'd1);
        check("adds_wb_sel", {30'd0, wb_sel}, 32'd0);
        check("adds_waddr", {23'd0, rf_waddr}, 32'd1);
        step();
        alu_flags = 4'b0000;
        check("adds_alu_op_after", {27'd0, alu_op}, 32'd0);
        check("adds_flags", {28'd0, flags}, 32'b0100);

        // CMP at PC 2 with Z=1
        fetch(mk(5'd18, 9'd0, 9'd1, 9'd2), 8'h02, 0);
        alu_flags = 4'b0100;
        step();
        check("cmp_alu_op", {27'd0, alu_op}, 32'd18);
        check("cmp_rf_we", {31'd0, rf_we}, 32'd0);
        step();
        alu_flags = 4'b0000;
        check("cmp_flags", {28'd0, flags}, 32'b0100);

        // BEQ taken at PC 3 -> 0x40 (two cycles)
        fetch({5'd23, 19'd0, 8'h40}, 8'h03, 0);
        step();
        check("beq_taken_addr", {24'd0, imem_addr}, 32'h40);

        // CMP with Z=0, then BEQ not taken
        fetch(mk(5'd18, 9'd0, 9'd1, 9'd2), 8'h40, 0);
        alu_flags = 4'b0001;
        step(); step();
        alu_flags = 4'b0000;
        check("cmp2_flags", {28'd0, flags}, 32'b0001);
        fetch({5'd23, 19'd0, 8'h80}, 8'h41, 0);
        step();
        check("beq_not_taken_addr", {24'd0, imem_addr}, 32'h42);

        // J 0xFF, then illegal opcode 27 at 0xFF with one wait cycle
        fetch({5'd22, 19'd0, 8'hFF}, 8'h42, 0);
        step();
        fetch(mk(5'd27, 9'd0, 9'd0, 9'd0), 8'hFF, 1);
        check("illegal_pulse", {31'd0, illegal}, 32'd1);
        step();
        check("illegal_cleared", {31'd0, illegal}, 32'd0);
        check("wrap_addr", {24'd0, imem_addr}, 32'h00);
        check("illegal_flags", {28'd0, flags}, 32'b0001);

        // LOAD r5,[0x07] at PC 0 with three dmem wait cycles
        fetch(mk(5'd19, 9'd5, 9'd7, 9'd0), 8'h00, 0);
        step();
        check("load_exec_dmem_req", {31'd0, dmem_req}, 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("load_dmem_req", {31'd0, dmem_req}, 32'd1);
            check("load_dmem_we", {31'd0, dmem_we}, 32'd0);
            check("load_dmem_addr", {23'd0, dmem_addr}, 32'd7);
            check("load_mem_rf_we", {31'd0, rf_we}, 32'd0);
            if (i == 3) dmem_ready = 1'b1;
            step();
        end
        dmem_ready = 1'b0;
        check("load_wb_rf_we", {31'd0, rf_we}, 32'd1);
        check("load_wb_sel", {30'd0, wb_sel}, 32'd1);
        check("load_wb_waddr", {23'd0, rf_waddr}, 32'd5);
        check("load_wb_dmem_req", {31'd0, dmem_req}, 32'd0);
        step();
        check("load_rf_we_after", {31'd0, rf_we}, 32'd0);

        // STORE [0x09],r2 at PC 1
        fetch(mk(5'd20, 9'd9, 9'd2, 9'd0), 8'h01, 0);
        check("store_raddr1", {23'd0, rf_raddr1}, 32'd2);
        rf_rdata1 = 32'hDEAD_BEEF;
        step();
        check("store_exec_rf_we", {31'd0, rf_we}, 32'd0);
        step();
        check("store_dmem_req", {31'd0, dmem_req}, 32'd1);
        check("store_dmem_we", {31'd0, dmem_we}, 32'd1);
        check("store_dmem_addr", {23'd0, dmem_addr}, 32'd9);
        check("store_dmem_wdata", dmem_wdata, 32'hDEAD_BEEF);
        check("store_mem_rf_we", {31'd0, rf_we}, 32'd0);
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        rf_rdata1  = '0;
        check("store_done_req", {31'd0, dmem_req}, 32'd0);
        check("store_done_rf_we", {31'd0, rf_we}, 32'd0);

        // Self-loop J 2 at PC 2, twice
        for (int i = 0; i < 2; i++) begin
            fetch({5'd22, 19'd0, 8'h02}, 8'h02, 0);
            step();
            check("selfloop_addr", {24'd0, imem_addr}, 32'h02);
        end

        // HLT at PC 2: absorbing, ready ignored
        fetch({5'd24, 27'd0}, 8'h02, 0);
        step();
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("halt_halted", {31'd0, halted}, 32'd1);
            check("halt_imem_req", {31'd0, imem_req}, 32'd0);
            step();
        end
        imem_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("halt_rst_halted", {31'd0, halted}, 32'd0);
        check("halt_rst_addr", {24'd0, imem_addr}, 32'd0);
        rst = 1'b1;
        step();
        check("restart_req", {31'd0, imem_req}, 32'd1);

        // LOAD then reset mid-MEM
        fetch(mk(5'd19, 9'd6, 9'd3, 9'd0), 8'h00, 0);
        step(); step();
        check("mid_mem_req", {31'd0, dmem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("midrst_dmem_addr", {23'd0, dmem_addr}, 32'd0);
        check("midrst_rf_raddr1", {23'd0, rf_raddr1}, 32'd0);
        check("midrst_imem_req", {31'd0, imem_req}, 32'd0);
        check("midrst_imem_addr", {24'd0, imem_addr}, 32'd0);
        check("midrst_imm", imm, 32'd0);
        check("midrst_flags", {28'd0, flags}, 32'd0);
        #1;
        rst = 1'b1;
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        check("midrst_no_rf_we", {31'd0, rf_we}, 32'd0);
        check("midrst_restart_req", {31'd0, imem_req}, 32'd1);
        check("midrst_restart_addr", {24'd0, imem_addr}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
